factor_game_ctrl: RTL and testbench

Parametrised top-level controller for the factorization game. Sequences a game of Q_NUM questions: requests a question from the question generator, waits for the player's decision, consumes the judge result, and tracks hit points, score and question count. It sits between the question generator, the judge and the display/HP units, and it drives the state code and status outputs those units decode.

---
 rtl/factor_game_ctrl_if.sv | 30 +++
 rtl/factor_game_ctrl.sv | 130 +++++++++++++
 tb/tb_factor_game_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/factor_game_ctrl_if.sv
// Bundle between the game controller and its environment.
// master: the controller side; slave: generator/judge/display side.
interface factor_game_ctrl_if #(
    parameter int HP_W = 2
);
    logic            OK_IN;
    logic            QUE_IN;
    logic            DEC_IN;
    logic [1:0]      JUDG_IN;
    logic            READY_OUT;
    logic            QUE_REQ;
    logic [3:0]      STATE;
    logic [HP_W-1:0] HP_OUT;
    logic [3:0]      SCORE;
    logic [3:0]      Q_CNT;
    logic            WIN;
    logic            LOSE;

    modport master (
        input  OK_IN, QUE_IN, DEC_IN, JUDG_IN,
        output READY_OUT, QUE_REQ, STATE, HP_OUT,
        output SCORE, Q_CNT, WIN, LOSE
    );

    modport slave (
        output OK_IN, QUE_IN, DEC_IN, JUDG_IN,
        input  READY_OUT, QUE_REQ, STATE, HP_OUT,
        input  SCORE, Q_CNT, WIN, LOSE
    );
endinterface

// File: rtl/factor_game_ctrl.sv
// Factorization game sequencer: questions, answers, HP and score.
// Answer timer compiled in only with FACT_CTRL_TIMEOUT_EN.
module factor_game_ctrl #(
    parameter int HP_W    = 2,
    parameter int HP_INIT = 3,
    parameter int Q_NUM   = 4,
    parameter int TIMEOUT = 1000
) (
    input logic CLK,
    input logic RST,
    factor_game_ctrl_if.master bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_REQ    = 4'd1;
    localparam logic [3:0] S_WAIT_Q = 4'd2;
    localparam logic [3:0] S_ANSWER = 4'd3;
    localparam logic [3:0] S_JUDGE  = 4'd4;
    localparam logic [3:0] S_HIT    = 4'd5;
    localparam logic [3:0] S_NEXT   = 4'd6;
    localparam logic [3:0] S_WIN    = 4'd7;
    localparam logic [3:0] S_LOSE   = 4'd8;

    localparam logic [3:0] Q_LAST = 4'(Q_NUM - 1);
    localparam logic [3:0] S_MAX  = 4'(Q_NUM);

    logic [3:0]      state_q, state_d;
    logic            ok_q;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [3:0]      score_q, score_d;
    logic [3:0]      q_cnt_q, q_cnt_d;
    logic            start;
    logic            tmr_zero;

    assign start = bus.OK_IN && !ok_q;

`ifdef FACT_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmr_q, tmr_d;

    assign tmr_zero = (tmr_q == '0);

    // Loaded on every path into ANSWER so a retry gets a full window
    always_comb begin
        tmr_d = tmr_q;
        if (state_q == S_WAIT_Q || state_q == S_HIT)
            tmr_d = TMR_LOAD;
        else if (state_q == S_ANSWER && !tmr_zero)
            tmr_d = tmr_q - TW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) tmr_q <= '0;
        else     tmr_q <= tmr_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmr_zero       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        score_d = score_q;
        q_cnt_d = q_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    hp_d    = HP_W'(HP_INIT);
                    score_d = 4'd0;
                    q_cnt_d = 4'd0;
                end
            end
            S_REQ:    state_d = S_WAIT_Q;
            S_WAIT_Q: if (bus.QUE_IN) state_d = S_ANSWER;
            S_ANSWER: begin
                if (bus.DEC_IN)    state_d = S_JUDGE;
                else if (tmr_zero) state_d = S_HIT;
            end
            S_JUDGE: begin
                if (bus.JUDG_IN == 2'b01)      state_d = S_NEXT;
                else if (bus.JUDG_IN == 2'b10) state_d = S_HIT;
            end
            S_HIT: begin
                if (hp_q != '0) hp_d = hp_q - HP_W'(1);
                state_d = (hp_q <= HP_W'(1)) ? S_LOSE : S_ANSWER;
            end
            S_NEXT: begin
                if (score_q < S_MAX) score_d = score_q + 4'd1;
                if (q_cnt_q >= Q_LAST) begin
                    state_d = S_WIN;
                end else begin
                    q_cnt_d = q_cnt_q + 4'd1;
                    state_d = S_REQ;
                end
            end
            S_WIN, S_LOSE: if (start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Edge register resets high so a button held through reset is ignored
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ok_q    <= 1'b1;
            hp_q    <= '0;
            score_q <= 4'd0;
            q_cnt_q <= 4'd0;
        end else begin
            state_q <= state_d;
            ok_q    <= bus.OK_IN;
            hp_q    <= hp_d;
            score_q <= score_d;
            q_cnt_q <= q_cnt_d;
        end
    end

    assign bus.STATE     = state_q;
    assign bus.READY_OUT = (state_q == S_IDLE);
    assign bus.QUE_REQ   = (state_q == S_REQ);
    assign bus.WIN       = (state_q == S_WIN);
    assign bus.LOSE      = (state_q == S_LOSE);
    assign bus.HP_OUT    = hp_q;
    assign bus.SCORE     = score_q;
    assign bus.Q_CNT     = q_cnt_q;
endmodule

// File: tb/tb_factor_game_ctrl.sv
// Directed bench for factor_game_ctrl (HP_INIT=3, Q_NUM=4, TIMEOUT=8).
// Covers win, lose, timeout/no-timeout, reset and button-edge cases.
module tb_factor_game_ctrl;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    factor_game_ctrl_if #(.HP_W(2)) bus ();

    factor_game_ctrl #(
        .HP_W(2), .HP_INIT(3), .Q_NUM(4), .TIMEOUT(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        bus.OK_IN = 1'b0;
        bus.QUE_IN = 1'b0;
        bus.DEC_IN = 1'b0;
        bus.JUDG_IN = 2'b00;
        tick();
        tick();
        chk("rst_state", bus.STATE, 0);
        chk("rst_ready", bus.READY_OUT, 1);
        chk("rst_quereq", bus.QUE_REQ, 0);
        chk("rst_hp", bus.HP_OUT, 0);
        chk("rst_score", bus.SCORE, 0);
        chk("rst_qcnt", bus.Q_CNT, 0);
        chk("rst_win", bus.WIN, 0);
        chk("rst_lose", bus.LOSE, 0);
        RST = 1'b0;
        tick();
        chk("idle_hold", bus.STATE, 0);

        bus.OK_IN = 1'b1;
        tick();
        chk("start_state", bus.STATE, 1);
        chk("start_quereq", bus.QUE_REQ, 1);
        chk("start_hp", bus.HP_OUT, 3);
        chk("start_ready", bus.READY_OUT, 0);
        bus.OK_IN = 1'b0;
        tick();
        chk("waitq_state", bus.STATE, 2);
        chk("waitq_quereq", bus.QUE_REQ, 0);

        for (int r = 0; r < 4; r++) begin
            bus.QUE_IN = 1'b1;
            tick();
            chk("win_answer", bus.STATE, 3);
            bus.QUE_IN = 1'b0;
            bus.DEC_IN = 1'b1;
            tick();
            chk("win_judge", bus.STATE, 4);
            bus.DEC_IN = 1'b0;
            bus.JUDG_IN = 2'b01;
            tick();
            chk("win_next", bus.STATE, 6);
            bus.JUDG_IN = 2'b00;
            tick();
            if (r < 3) begin
                chk("win_req", bus.STATE, 1);
                chk("win_score", bus.SCORE, r + 1);
                chk("win_qcnt", bus.Q_CNT, r + 1);
                tick();
                chk("win_waitq", bus.STATE, 2);
            end
        end
        chk("win_state", bus.STATE, 7);
        chk("win_flag", bus.WIN, 1);
        chk("win_final_score", bus.SCORE, 4);
        chk("win_final_qcnt", bus.Q_CNT, 3);
        chk("win_final_hp", bus.HP_OUT, 3);
        tick();
        chk("win_hold", bus.STATE, 7);

        bus.OK_IN = 1'b1;
        tick();
        chk("win_to_idle", bus.STATE, 0);
        chk("win_to_idle_ready", bus.READY_OUT, 1);
        bus.OK_IN = 1'b0;
        tick();
        chk("idle_wait2", bus.STATE, 0);
        bus.OK_IN = 1'b1;
        tick();
        chk("g2_req", bus.STATE, 1);
        chk("g2_score", bus.SCORE, 0);
        chk("g2_qcnt", bus.Q_CNT, 0);
        bus.OK_IN = 1'b0;
        tick();
        bus.QUE_IN = 1'b1;
        tick();
        bus.QUE_IN = 1'b0;
        chk("g2_answer", bus.STATE, 3);

        for (int k = 0; k < 2; k++) begin
            bus.DEC_IN = 1'b1;
            tick();
            bus.DEC_IN = 1'b0;
            bus.JUDG_IN = 2'b10;
            tick();
            bus.JUDG_IN = 2'b00;
            chk("lose_hit", bus.STATE, 5);
            tick();
            chk("lose_retry", bus.STATE, 3);
            chk("lose_hp", bus.HP_OUT, 2 - k);
        end
        bus.DEC_IN = 1'b1;
        tick();
        bus.DEC_IN = 1'b0;
        bus.JUDG_IN = 2'b10;
        tick();
        bus.JUDG_IN = 2'b00;
        chk("lose_hit3", bus.STATE, 5);
        tick();
        chk("lose_state", bus.STATE, 8);
        chk("lose_flag", bus.LOSE, 1);
        chk("lose_hp0", bus.HP_OUT, 0);
        chk("lose_qcnt", bus.Q_CNT, 0);

        bus.OK_IN = 1'b1;
        tick();
        chk("lose_to_idle", bus.STATE, 0);
        bus.OK_IN = 1'b0;
        tick();
        bus.OK_IN = 1'b1;
        tick();
        bus.OK_IN = 1'b0;
        tick();
        bus.QUE_IN = 1'b1;
        tick();
        bus.QUE_IN = 1'b0;
        chk("g3_answer", bus.STATE, 3);

`ifdef FACT_CTRL_TIMEOUT_EN
        for (int c = 1; c < 8; c++) begin
            tick();
            chk("tmo_hold", bus.STATE, 3);
        end
        tick();
        chk("tmo_hit", bus.STATE, 5);
        tick();
        chk("tmo_retry", bus.STATE, 3);
        chk("tmo_hp", bus.HP_OUT, 2);
        for (int c = 1; c < 8; c++) tick();
        chk("tmo_edge_hold", bus.STATE, 3);
        bus.DEC_IN = 1'b1;
        tick();
        bus.DEC_IN = 1'b0;
        chk("tmo_dec_wins", bus.STATE, 4);
        chk("tmo_dec_hp", bus.HP_OUT, 2);
`else
        for (int c = 0; c < 100; c++) tick();
        chk("notmo_hold", bus.STATE, 3);
        chk("notmo_hp", bus.HP_OUT, 3);
        bus.DEC_IN = 1'b1;
        tick();
        bus.DEC_IN = 1'b0;
        chk("notmo_judge", bus.STATE, 4);
`endif
        tick();
        chk("judge_hold", bus.STATE, 4);

        #2;
        RST = 1'b1;
        #1;
        chk("midrst_state", bus.STATE, 0);
        chk("midrst_score", bus.SCORE, 0);
        chk("midrst_hp", bus.HP_OUT, 0);

        bus.OK_IN = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        chk("okheld_idle1", bus.STATE, 0);
        tick();
        chk("okheld_idle2", bus.STATE, 0);
        bus.OK_IN = 1'b0;
        tick();
        bus.OK_IN = 1'b1;
        tick();
        chk("okheld_then_start", bus.STATE, 1);
        bus.OK_IN = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
